rcb_spi_slave_gen: RTL
======================

Name: rcb_spi_slave_gen

Overview:
- Parametrised second-generation SPI slave for the RCB FPGA. Bridges an external SPI master to the internal register bus.
- Supports all four SPI modes (CPOL/CPHA), configurable command/address/data widths, and multi-word burst transfers with address auto-increment.
- Read data comes through an explicit request/valid handshake; protocol errors are flagged.
- Sits between the board SPI pins and the register-file decoder in rcb_top.

Parameters:
- CMD_W, 8, command field width in bits.
- ADDR_W, 16, address field width in bits.
- DATA_W, 32, data word width in bits.
- CPOL, 0, SCLK idle level.
- CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge.
- WRITE_CMD, 8'h0A, write command code.
- READ_CMD, 8'h0F, read command code.

Ports:
- clk_100m  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- sclk  in  1  SPI clock (asynchronous).
- cs_n  in  1  SPI chip select, active low (asynchronous).
- mosi  in  1  master-to-slave serial data.
- miso  out  1  slave-to-master serial data.
- wr_valid  out  1  one-cycle pulse: a write word is complete.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  DATA_W  write data.
- rd_req  out  1  one-cycle pulse: read data is requested.
- rd_addr  out  ADDR_W  read address.
- rd_valid  in  1  rd_data is valid this cycle.
- rd_data  in  DATA_W  read data.
- cmd_err  out  1  one-cycle pulse: undefined command received.
- rd_underrun  out  1  one-cycle pulse: read data arrived too late.
- busy  out  1  high while a transaction is active.

Behaviour:
- Reset (async, rst=1):
  - All outputs 0 except miso=1.
  - State IDLE, counters 0, address register 0.
- Synchronisation:
  - sclk, cs_n and mosi each pass through a 2-FF synchroniser.
  - Edge detect adds 1 cycle, so 3 clk from pin to internal event.
  - Supported SCLK frequency: at most clk_100m/8.
- Edge roles:
  - Leading edge = transition away from the CPOL level.
  - CPHA=0: sample on leading edge, shift on trailing edge. The first MISO bit of a word is driven on the trailing edge of the preceding bit.
  - CPHA=1: shift on leading edge, sample on trailing edge.
- Bit order: MSB first for every field.
- FSM states: IDLE, CMD, ADDR, WR_DATA, RD_DATA, DISCARD.
  - IDLE -> CMD: synchronised cs_n falls. busy=1, bit_cnt=0.
  - CMD -> ADDR: after CMD_W sample events.
    - Command decoded: WRITE_CMD -> write, READ_CMD -> read, any other value -> discard with a cmd_err pulse.
  - ADDR -> WR_DATA / RD_DATA / DISCARD: after ADDR_W sample events. The address register loads.
  - WR_DATA: after each DATA_W sample events, pulse wr_valid for 1 cycle with wr_addr=address and wr_data=word, then address increments. Stays in WR_DATA for a burst.
  - RD_DATA: see read path below.
  - DISCARD: shifts and ignores all bits until cs_n rises. No wr_valid, no rd_req.
  - Any state -> IDLE: synchronised cs_n rises. Takes priority over a simultaneous sample event.
    - A partial word is dropped: no wr_valid.
    - miso=1, busy=0 on the following cycle.
- Read path:
  - rd_req pulses 1 cycle after the last address bit is sampled, with rd_addr=address.
  - The word is captured on the cycle rd_valid=1. rd_valid seen while no request is outstanding is ignored.
  - If no rd_valid arrives before the first shift event of the word, the word is sent as all ones and rd_underrun pulses.
  - Burst prefetch: at the first shift event of word n, rd_req for address+1 is issued. The read for word n+1 may therefore be speculative; read-side-effect registers must tolerate this.
- Address arithmetic: increments by 1 per word, modulo 2^ADDR_W (wrap FFFF -> 0000 at the default width).
- MISO:
  - Held at 1 in IDLE, CMD, ADDR, WR_DATA and DISCARD.
  - In RD_DATA, shifts the captured word MSB first.
- Reset mid-transaction: immediate return to IDLE. No output pulses are generated.

Decomposition:
- Package rcb_spi_pkg:
  - state encoding;
  - default command codes;
  - mode codes (write/read/discard);
  - clog2 function for the bit counter width, sized to max(CMD_W, ADDR_W, DATA_W).
- Sub-module rcb_spi_sync: 2-FF synchronisers plus CPOL/CPHA-aware sample_en / shift_en / cs_fall / cs_rise generation.

Test Plan:
- Mode 0, write cmd 0x0A, address 0x0010, data 0xDEADBEEF -> exactly one wr_valid with wr_addr=0x0010, wr_data=0xDEADBEEF; miso stays 1.
- Mode 3 read at 0x0004, rd_valid 2 clk after rd_req with 0x12345678 -> MISO shifts 0x12345678; rd_req for 0x0005 issued at the first data shift.
- Mode 1 burst write of 3 words at 0xFFFF -> wr_valid at addresses 0xFFFF, 0x0000, 0x0001.
- Command 0x55 followed by 48 bits -> cmd_err pulses once; no wr_valid or rd_req; miso=1 throughout.
- Read with rd_valid withheld -> word 0xFFFFFFFF on MISO and one rd_underrun pulse.
- cs_n rises after 20 data bits of a write, then rst asserted during a new command -> no wr_valid in either case; state IDLE, busy=0, miso=1.

Source files
------------

// File: rtl/rcb_spi_slave_gen_pkg.sv
// rcb_spi_pkg: shared types and helpers for the RCB second-generation SPI slave.
//   state_t : transaction FSM states
//   mode_t  : decoded command class (write / read / discard)
//   DEF_*   : default command codes
//   clog2 / max3 : sizing helpers for the bit counter
package rcb_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WR_DATA,
    ST_RD_DATA,
    ST_DISCARD
  } state_t;

  typedef enum logic [1:0] {
    MODE_WRITE,
    MODE_READ,
    MODE_DISCARD
  } mode_t;

  localparam logic [7:0] DEF_WRITE_CMD = 8'h0A;
  localparam logic [7:0] DEF_READ_CMD  = 8'h0F;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned span;
    res  = 0;
    span = 1;
    while (span < value) begin
      span = span << 1;
      res++;
    end
    return res;
  endfunction

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rcb_spi_slave_gen_sync.sv
// rcb_spi_sync: brings the asynchronous SPI pins into the clk_100m domain and
// turns SCLK transitions into mode-aware single-cycle strobes.
//   clk_100m, rst     : system clock, async active-high reset
//   sclk, cs_n, mosi  : raw SPI pins
//   sample_en         : MOSI sampling edge (leading for CPHA=0, trailing for CPHA=1)
//   shift_en          : MISO shifting edge (the other edge)
//   cs_fall, cs_rise  : synchronised chip-select transitions
//   mosi_s            : synchronised MOSI, aligned with the edge strobes
module rcb_spi_sync #(
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0
) (
  input  logic clk_100m,
  input  logic rst,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic sample_en,
  output logic shift_en,
  output logic cs_fall,
  output logic cs_rise,
  output logic mosi_s
);

  logic [1:0] sclk_ff;
  logic [1:0] cs_ff;
  logic [1:0] mosi_ff;
  logic       sclk_d;
  logic       cs_d;
  logic       lead;
  logic       trail;
  logic       active;

  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      sclk_ff <= {2{CPOL}};
      cs_ff   <= '1;
      mosi_ff <= '0;
      sclk_d  <= CPOL;
      cs_d    <= 1'b1;
    end else begin
      sclk_ff <= {sclk_ff[0], sclk};
      cs_ff   <= {cs_ff[0], cs_n};
      mosi_ff <= {mosi_ff[0], mosi};
      sclk_d  <= sclk_ff[1];
      cs_d    <= cs_ff[1];
    end
  end

  // MOSI runs through the same two stages as SCLK, so mosi_s is the pin value
  // at the moment of the edge that raised sample_en.
  always_comb begin
    lead      = (sclk_ff[1] != CPOL) && (sclk_d == CPOL);
    trail     = (sclk_ff[1] == CPOL) && (sclk_d != CPOL);
    active    = ~cs_ff[1];
    sample_en = active & (CPHA ? trail : lead);
    shift_en  = active & (CPHA ? lead : trail);
    cs_fall   = ~cs_ff[1] & cs_d;
    cs_rise   = cs_ff[1] & ~cs_d;
    mosi_s    = mosi_ff[1];
  end

endmodule

// File: rtl/rcb_spi_slave_gen.sv
// rcb_spi_slave_gen: SPI slave bridging an external master to the register bus.
// Frame: command (CMD_W) | address (ADDR_W) | data words (DATA_W each), MSB first.
//   clk_100m, rst       : system clock, async active-high reset
//   sclk, cs_n, mosi    : SPI pins in; miso : SPI data out (1 when not reading)
//   wr_valid/addr/data  : one-cycle write strobe per completed write word
//   rd_req/rd_addr      : one-cycle read request; rd_valid/rd_data : response
//   cmd_err             : pulse on an undefined command
//   rd_underrun         : pulse when a read word had to be sent as all ones
//   busy                : transaction in progress
module rcb_spi_slave_gen
  import rcb_spi_pkg::*;
#(
  parameter int unsigned           CMD_W     = 8,
  parameter int unsigned           ADDR_W    = 16,
  parameter int unsigned           DATA_W    = 32,
  parameter bit                    CPOL      = 1'b0,
  parameter bit                    CPHA      = 1'b0,
  parameter logic [CMD_W-1:0]      WRITE_CMD = CMD_W'(DEF_WRITE_CMD),
  parameter logic [CMD_W-1:0]      READ_CMD  = CMD_W'(DEF_READ_CMD)
) (
  input  logic              clk_100m,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              cmd_err,
  output logic              rd_underrun,
  output logic              busy
);

  localparam int unsigned MAX_W = max3(CMD_W, ADDR_W, DATA_W);
  localparam int unsigned CNT_W = (clog2(MAX_W) < 1) ? 1 : clog2(MAX_W);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  logic sample_en, shift_en, cs_fall, cs_rise, mosi_s;

  rcb_spi_sync #(
    .CPOL (CPOL),
    .CPHA (CPHA)
  ) u_sync (
    .clk_100m  (clk_100m),
    .rst       (rst),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .sample_en (sample_en),
    .shift_en  (shift_en),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise),
    .mosi_s    (mosi_s)
  );

  state_t              state_q, state_d;
  mode_t               mode_q, mode_d, mode_dec;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d, cnt_inc;
  logic [MAX_W-2:0]    shreg_q, shreg_d;
  logic [MAX_W-1:0]    shreg_in;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rd_buf_q, rd_buf_d;
  logic [DATA_W-1:0]   load_word;
  logic                rd_pend_q, rd_pend_d;
  logic                rd_have_q, rd_have_d;
  logic                need_load_q, need_load_d;
  logic                miso_d, wr_valid_d, rd_req_d, cmd_err_d, rd_underrun_d;
  logic [ADDR_W-1:0]   wr_addr_d, rd_addr_d;
  logic [DATA_W-1:0]   wr_data_d;

  assign busy = (state_q != ST_IDLE);

  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_DISCARD;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      addr_q      <= '0;
      tx_q        <= '1;
      rd_buf_q    <= '0;
      rd_pend_q   <= 1'b0;
      rd_have_q   <= 1'b0;
      need_load_q <= 1'b0;
      miso        <= 1'b1;
      wr_valid    <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      rd_req      <= 1'b0;
      rd_addr     <= '0;
      cmd_err     <= 1'b0;
      rd_underrun <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      addr_q      <= addr_d;
      tx_q        <= tx_d;
      rd_buf_q    <= rd_buf_d;
      rd_pend_q   <= rd_pend_d;
      rd_have_q   <= rd_have_d;
      need_load_q <= need_load_d;
      miso        <= miso_d;
      wr_valid    <= wr_valid_d;
      wr_addr     <= wr_addr_d;
      wr_data     <= wr_data_d;
      rd_req      <= rd_req_d;
      rd_addr     <= rd_addr_d;
      cmd_err     <= cmd_err_d;
      rd_underrun <= rd_underrun_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    bit_cnt_d     = bit_cnt_q;
    shreg_d       = shreg_q;
    addr_d        = addr_q;
    tx_d          = tx_q;
    rd_buf_d      = rd_buf_q;
    rd_pend_d     = rd_pend_q;
    rd_have_d     = rd_have_q;
    need_load_d   = need_load_q;
    miso_d        = 1'b1;
    wr_valid_d    = 1'b0;
    wr_addr_d     = wr_addr;
    wr_data_d     = wr_data;
    rd_req_d      = 1'b0;
    rd_addr_d     = rd_addr;
    cmd_err_d     = 1'b0;
    rd_underrun_d = 1'b0;
    load_word     = '1;
    mode_dec      = MODE_DISCARD;
    shreg_in      = {shreg_q, mosi_s};
    cnt_inc       = bit_cnt_q + CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        rd_pend_d   = 1'b0;
        rd_have_d   = 1'b0;
        need_load_d = 1'b0;
        if (cs_fall) begin
          state_d   = ST_CMD;
          bit_cnt_d = '0;
        end
      end

      ST_CMD: begin
        if (sample_en) begin
          shreg_d   = shreg_in[MAX_W-2:0];
          bit_cnt_d = cnt_inc;
          if (bit_cnt_q == CMD_LAST) begin
            if (shreg_in[CMD_W-1:0] == WRITE_CMD)
              mode_dec = MODE_WRITE;
            else if (shreg_in[CMD_W-1:0] == READ_CMD)
              mode_dec = MODE_READ;
            mode_d    = mode_dec;
            cmd_err_d = (mode_dec == MODE_DISCARD);
            bit_cnt_d = '0;
            state_d   = ST_ADDR;
          end
        end
      end

      ST_ADDR: begin
        if (sample_en) begin
          shreg_d   = shreg_in[MAX_W-2:0];
          bit_cnt_d = cnt_inc;
          if (bit_cnt_q == ADDR_LAST) begin
            addr_d    = shreg_in[ADDR_W-1:0];
            bit_cnt_d = '0;
            case (mode_q)
              MODE_WRITE: state_d = ST_WR_DATA;
              MODE_READ: begin
                state_d     = ST_RD_DATA;
                rd_req_d    = 1'b1;
                rd_addr_d   = shreg_in[ADDR_W-1:0];
                rd_pend_d   = 1'b1;
                rd_have_d   = 1'b0;
                need_load_d = 1'b1;
              end
              default: state_d = ST_DISCARD;
            endcase
          end
        end
      end

      ST_WR_DATA: begin
        if (sample_en) begin
          shreg_d   = shreg_in[MAX_W-2:0];
          bit_cnt_d = cnt_inc;
          if (bit_cnt_q == DATA_LAST) begin
            wr_valid_d = 1'b1;
            wr_addr_d  = addr_q;
            wr_data_d  = shreg_in[DATA_W-1:0];
            addr_d     = addr_q + ADDR_W'(1);
            bit_cnt_d  = '0;
          end
        end
      end

      ST_RD_DATA: begin
        miso_d = miso;
        if (rd_valid && rd_pend_q) begin
          rd_buf_d  = rd_data;
          rd_have_d = 1'b1;
          rd_pend_d = 1'b0;
        end
        // The first shift of each word commits it to MISO and prefetches the
        // next address; a response landing on that same cycle is too late and
        // is dropped so it cannot be mistaken for the prefetch's answer.
        if (shift_en) begin
          if (need_load_q) begin
            load_word     = rd_have_q ? rd_buf_q : '1;
            rd_underrun_d = ~rd_have_q;
            miso_d        = load_word[DATA_W-1];
            tx_d          = {load_word[DATA_W-2:0], 1'b1};
            need_load_d   = 1'b0;
            rd_req_d      = 1'b1;
            rd_addr_d     = addr_q + ADDR_W'(1);
            rd_pend_d     = 1'b1;
            rd_have_d     = 1'b0;
          end else begin
            miso_d = tx_q[DATA_W-1];
            tx_d   = {tx_q[DATA_W-2:0], 1'b1};
          end
        end
        if (sample_en) begin
          bit_cnt_d = cnt_inc;
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d   = '0;
            addr_d      = addr_q + ADDR_W'(1);
            need_load_d = 1'b1;
          end
        end
      end

      ST_DISCARD: begin
      end

      default: state_d = ST_IDLE;
    endcase

    // Chip-select release ends the frame regardless of any coincident edge.
    if (state_q != ST_IDLE && cs_rise) begin
      state_d       = ST_IDLE;
      bit_cnt_d     = '0;
      rd_pend_d     = 1'b0;
      rd_have_d     = 1'b0;
      need_load_d   = 1'b0;
      miso_d        = 1'b1;
      wr_valid_d    = 1'b0;
      wr_addr_d     = wr_addr;
      wr_data_d     = wr_data;
      rd_req_d      = 1'b0;
      rd_addr_d     = rd_addr;
      cmd_err_d     = 1'b0;
      rd_underrun_d = 1'b0;
    end
  end

endmodule
